pic_host_bus_master: RTL and testbench
======================================

Name: pic_host_bus_master

Overview:
- CPU-side bus initiator for the 8259A PIC block; it drives the opposite end of the PIC's CS_n/A0/RD_n/WR_n/INTA_n/D interface.
- Turns a simple valid/ready command port into correctly timed ICW/OCW write cycles and status read cycles.
- Watches the PIC's INT line and, when enabled, runs the two-pulse interrupt-acknowledge sequence, capturing the 8-bit vector from D on the second pulse.
- Used as the bench/system host for the PIC and as the SoC glue toward a synchronous CPU core.

Parameters:
- PULSE_CYCLES, 2, low width in clk cycles of every RD_n, WR_n and INTA_n strobe; legal range 1..15.
- GAP_CYCLES, 2, high time between the two INTA_n pulses, and recovery time after every bus cycle; legal range 1..15.
- SYNC_STAGES, 2, flip-flop stages synchronising INT; legal range 2..3.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE when no acknowledge is starting.
- cmd_write  in  1  1 = write cycle, 0 = read cycle.
- cmd_a0  in  1  value driven on A0.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  8  captured read data.
- int_enable  in  1  CPU interrupt enable (IF flag).
- vec_valid  out  1  one-cycle pulse, vector captured.
- vec_data  out  8  captured vector.
- INT  in  1  from PIC, asynchronous.
- D_in  in  8  data bus sampled from PIC.
- D_out  out  8  data bus driven toward PIC.
- D_oe  out  1  D_out drive enable.
- CS_n  out  1  PIC chip select.
- A0  out  1  PIC register select.
- RD_n  out  1  read strobe.
- WR_n  out  1  write strobe.
- INTA_n  out  1  interrupt acknowledge strobe.

Behaviour:
- All bus outputs are registered; no glitches.
- Reset values: CS_n, RD_n, WR_n, INTA_n = 1; D_oe = 0; D_out = 0; A0 = 0; rsp_valid = vec_valid = 0; rsp_rdata = vec_data = 0; synchroniser = 0; FSM = IDLE.
- Reset asserted mid-cycle forces these values immediately; the transaction is dropped with no response.
- INT_s is INT after SYNC_STAGES flops.
- States: IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, ACK1, AGAP, ACK2, RECOVER. A single 4-bit down-counter times every strobe and gap.
- IDLE arbitration: if INT_s & int_enable, go to ACK1 and hold cmd_ready = 0 in that cycle. Interrupt wins over a simultaneous cmd_valid. Otherwise, cmd_valid & cmd_ready accepts the command, latches a0/wdata/write and goes to SETUP.
- SETUP (1 cycle):
  - CS_n = 0, A0 = latched value.
  - For a write, D_oe = 1 and D_out = wdata.
  - Next state is WSTROBE or RSTROBE.
- WSTROBE: WR_n = 0 for PULSE_CYCLES, then WHOLD.
- WHOLD (1 cycle): WR_n = 1, while CS_n, A0 and D are still held. Then RECOVER.
- RSTROBE:
  - RD_n = 0 for PULSE_CYCLES.
  - D_in is sampled into rsp_rdata on the clock edge that ends the last low cycle; RD_n rises on the same edge.
  - rsp_valid = 1 for the first RECOVER cycle.
- ACK1: INTA_n = 0 for PULSE_CYCLES, CS_n = 1, D_oe = 0. Then AGAP.
- AGAP: INTA_n = 1 for GAP_CYCLES. Then ACK2.
- ACK2:
  - INTA_n = 0 for PULSE_CYCLES.
  - D_in is sampled into vec_data on the edge that ends the last low cycle.
  - vec_valid = 1 for the first RECOVER cycle.
- RECOVER:
  - All strobes high, CS_n = 1, D_oe = 0.
  - Lasts GAP_CYCLES, then IDLE.
  - INT is not re-evaluated until IDLE, so the PIC has time to drop INT.
- Once ACK1 starts, the sequence always completes, even if INT or int_enable drops (8259 spurious IR7 semantics). The vector is delivered as read.
- CS_n and INTA_n are never low at the same time. RD_n and WR_n are never low at the same time.
- cmd inputs are ignored when not accepted. Latched command fields are stable for the whole cycle.

Test Plan:
- PULSE = 2, GAP = 2. Write cmd_a0 = 0, cmd_wdata = 0x13 accepted at cycle t:
  - CS_n is low for t+1..t+4 and WR_n is low for t+2..t+3.
  - D_out = 0x13 with D_oe = 1 over t+1..t+4.
  - cmd_ready returns at t+7.
- Read cmd_a0 = 1 with D_in = 0xA5:
  - RD_n is low for 2 cycles.
  - rsp_valid pulses once with rsp_rdata = 0xA5.
  - D_oe stays 0 throughout.
- INT raised with int_enable = 1 and D_in = 0x48 during the second pulse:
  - INTA_n goes low 2, high 2, low 2; CS_n stays 1.
  - vec_valid pulses once with vec_data = 0x48.
- INT and cmd_valid rise together in IDLE:
  - The acknowledge sequence runs first.
  - The command is accepted only after RECOVER.
- INT falls during AGAP:
  - The second INTA pulse still occurs.
  - vec_valid reports D_in (e.g. 0x4F).
- rst_n pulsed low during WSTROBE:
  - WR_n and CS_n go to 1 asynchronously and D_oe goes to 0.
  - No rsp_valid is generated; cmd_ready = 1 after release.

Source files
------------

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for the 8259A PIC bus: timed ICW/OCW writes, status reads
// and the two-pulse interrupt-acknowledge sequence with vector capture.
module pic_host_bus_master #(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic       cmd_a0,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   input  logic       int_enable,
   output logic       vec_valid,
   output logic [7:0] vec_data,
   input  logic       INT,
   input  logic [7:0] D_in,
   output logic [7:0] D_out,
   output logic       D_oe,
   output logic       CS_n,
   output logic       A0,
   output logic       RD_n,
   output logic       WR_n,
   output logic       INTA_n
);

   typedef enum logic [3:0] {
      IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, ACK1, AGAP, ACK2, RECOVER
   } state_t;

   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   int_s;
   state_t                 state_r, state_nxt;
   logic [3:0]             cnt_r, cnt_nxt;
   logic                   lat_write_r, lat_write_nxt;
   logic                   lat_a0_r, lat_a0_nxt;
   logic [7:0]             lat_wdata_r, lat_wdata_nxt;
   logic                   cap_rsp, cap_vec;
   logic                   cs_n_nxt, a0_nxt, rd_n_nxt, wr_n_nxt, inta_n_nxt, oe_nxt;
   logic [7:0]             dout_nxt;

   assign int_s     = sync_r[SYNC_STAGES-1];
   assign cmd_ready = (state_r == IDLE) && !(int_s && int_enable);

   // INT synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], INT};
      end
   end

   // Next state, strobe timer and command latch
   always_comb begin
      state_nxt     = state_r;
      cnt_nxt       = cnt_r;
      lat_write_nxt = lat_write_r;
      lat_a0_nxt    = lat_a0_r;
      lat_wdata_nxt = lat_wdata_r;
      cap_rsp       = 1'b0;
      cap_vec       = 1'b0;
      case (state_r)
         IDLE: begin
            if (int_s && int_enable) begin
               state_nxt = ACK1;
               cnt_nxt   = PULSE_LOAD;
            end else if (cmd_valid) begin
               state_nxt     = SETUP;
               lat_write_nxt = cmd_write;
               lat_a0_nxt    = cmd_a0;
               lat_wdata_nxt = cmd_wdata;
            end else begin
               state_nxt = IDLE;
            end
         end
         SETUP: begin
            cnt_nxt   = PULSE_LOAD;
            state_nxt = lat_write_r ? WSTROBE : RSTROBE;
         end
         WSTROBE: begin
            if (cnt_r == 4'd0) begin
               state_nxt = WHOLD;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         WHOLD: begin
            state_nxt = RECOVER;
            cnt_nxt   = GAP_LOAD;
         end
         RSTROBE: begin
            if (cnt_r == 4'd0) begin
               state_nxt = RECOVER;
               cnt_nxt   = GAP_LOAD;
               cap_rsp   = 1'b1;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         ACK1: begin
            if (cnt_r == 4'd0) begin
               state_nxt = AGAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         AGAP: begin
            if (cnt_r == 4'd0) begin
               state_nxt = ACK2;
               cnt_nxt   = PULSE_LOAD;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         ACK2: begin
            if (cnt_r == 4'd0) begin
               state_nxt = RECOVER;
               cnt_nxt   = GAP_LOAD;
               cap_vec   = 1'b1;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         RECOVER: begin
            if (cnt_r == 4'd0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Bus pin values decoded from the upcoming state so the pins can be registered
   always_comb begin
      cs_n_nxt   = 1'b1;
      a0_nxt     = 1'b0;
      rd_n_nxt   = 1'b1;
      wr_n_nxt   = 1'b1;
      inta_n_nxt = 1'b1;
      oe_nxt     = 1'b0;
      dout_nxt   = 8'h00;
      case (state_nxt)
         SETUP: begin
            cs_n_nxt = 1'b0;
            a0_nxt   = lat_a0_nxt;
            oe_nxt   = lat_write_nxt;
            dout_nxt = lat_write_nxt ? lat_wdata_nxt : 8'h00;
         end
         WSTROBE: begin
            cs_n_nxt = 1'b0;
            a0_nxt   = lat_a0_nxt;
            wr_n_nxt = 1'b0;
            oe_nxt   = 1'b1;
            dout_nxt = lat_wdata_nxt;
         end
         WHOLD: begin
            cs_n_nxt = 1'b0;
            a0_nxt   = lat_a0_nxt;
            oe_nxt   = 1'b1;
            dout_nxt = lat_wdata_nxt;
         end
         RSTROBE: begin
            cs_n_nxt = 1'b0;
            a0_nxt   = lat_a0_nxt;
            rd_n_nxt = 1'b0;
         end
         ACK1, ACK2: begin
            inta_n_nxt = 1'b0;
         end
         default: begin
            cs_n_nxt = 1'b1;
         end
      endcase
   end

   // State, latch and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         lat_write_r <= 1'b0;
         lat_a0_r    <= 1'b0;
         lat_wdata_r <= 8'h00;
         CS_n        <= 1'b1;
         A0          <= 1'b0;
         RD_n        <= 1'b1;
         WR_n        <= 1'b1;
         INTA_n      <= 1'b1;
         D_oe        <= 1'b0;
         D_out       <= 8'h00;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 8'h00;
         vec_valid   <= 1'b0;
         vec_data    <= 8'h00;
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         lat_write_r <= lat_write_nxt;
         lat_a0_r    <= lat_a0_nxt;
         lat_wdata_r <= lat_wdata_nxt;
         CS_n        <= cs_n_nxt;
         A0          <= a0_nxt;
         RD_n        <= rd_n_nxt;
         WR_n        <= wr_n_nxt;
         INTA_n      <= inta_n_nxt;
         D_oe        <= oe_nxt;
         D_out       <= dout_nxt;
         rsp_valid   <= cap_rsp;
         vec_valid   <= cap_vec;
         if (cap_rsp) begin
            rsp_rdata <= D_in;
         end
         if (cap_vec) begin
            vec_data <= D_in;
         end
      end
   end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: a cycle-expectation queue built from
// the bus-cycle rules, checked every cycle, plus hand-computed literal checks.
module tb_pic_host_bus_master;
   localparam int P = 2;
   localparam int G = 2;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_a0 = 1'b0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       int_enable = 1'b0, INT = 1'b0;
   logic [7:0] D_in = 8'h00;
   logic       cmd_ready, rsp_valid, vec_valid, D_oe, CS_n, A0, RD_n, WR_n, INTA_n;
   logic [7:0] rsp_rdata, vec_data, D_out;

   pic_host_bus_master #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .int_enable(int_enable),
      .vec_valid(vec_valid), .vec_data(vec_data), .INT(INT), .D_in(D_in),
      .D_out(D_out), .D_oe(D_oe), .CS_n(CS_n), .A0(A0), .RD_n(RD_n),
      .WR_n(WR_n), .INTA_n(INTA_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       cs_n, a0, rd_n, wr_n, inta_n, oe;
      logic [7:0] dout;
      logic       rsp_v, vec_v, samp_r, samp_v;
   } exp_t;

   exp_t       q[$];
   logic [S-1:0] h = '0;
   logic [7:0] m_rdata = 8'h00, m_vec = 8'h00;
   logic       cur_idle = 1'b1, cur_samp_r = 1'b0, cur_samp_v = 1'b0;
   int         nvec = 0, nerr = 0;
   int         cyc = 0, cs_lo = 0, wr_lo = 0, rd_lo = 0, inta_lo = 0, oe_hi = 0;
   int         rspv_cnt = 0, vecv_cnt = 0, first_cs = -1, first_inta = -1;
   int         overlap_ci = 0, overlap_rw = 0;

   function automatic exp_t mk(logic cs, logic a, logic rd, logic wr, logic ia, logic oe,
                               logic [7:0] d, logic rv, logic vv, logic sr, logic sv);
      exp_t e;
      e.cs_n = cs; e.a0 = a; e.rd_n = rd; e.wr_n = wr; e.inta_n = ia; e.oe = oe;
      e.dout = d; e.rsp_v = rv; e.vec_v = vv; e.samp_r = sr; e.samp_v = sv;
      return e;
   endfunction

   function automatic exp_t idle_e();
      return mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Expected pin activity of each bus cycle type, one entry per clk cycle
   task automatic push_write(input logic a, input logic [7:0] d);
      q.push_back(mk(1'b0, a, 1'b1, 1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < P; i++)
         q.push_back(mk(1'b0, a, 1'b1, 1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b0, a, 1'b1, 1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < G; i++) q.push_back(idle_e());
   endtask

   task automatic push_read(input logic a);
      q.push_back(mk(1'b0, a, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < P; i++)
         q.push_back(mk(1'b0, a, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, i == P - 1, 1'b0));
      for (int i = 0; i < G; i++) begin
         exp_t e = idle_e();
         e.rsp_v = (i == 0);
         q.push_back(e);
      end
   endtask

   task automatic push_ack();
      for (int i = 0; i < P; i++)
         q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < G; i++) q.push_back(idle_e());
      for (int i = 0; i < P; i++)
         q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, i == P - 1));
      for (int i = 0; i < G; i++) begin
         exp_t e = idle_e();
         e.vec_v = (i == 0);
         q.push_back(e);
      end
   endtask

   // Model: captures, IDLE arbitration and INT synchronisation at each clock edge
   always @(posedge clk) begin
      if (rst_n) begin
         if (cur_samp_r) m_rdata = D_in;
         if (cur_samp_v) m_vec = D_in;
         if (cur_idle) begin
            if (h[S-1] && int_enable) push_ack();
            else if (cmd_valid && cmd_write) push_write(cmd_a0, cmd_wdata);
            else if (cmd_valid) push_read(cmd_a0);
         end
         h = {h[S-2:0], INT};
      end
   end

   // Compare process plus activity monitors
   always @(negedge clk) begin
      exp_t e;
      logic busy;
      busy = (q.size() > 0);
      e = busy ? q.pop_front() : idle_e();
      cur_idle = !busy;
      cur_samp_r = e.samp_r;
      cur_samp_v = e.samp_v;
      check("CS_n", CS_n, e.cs_n);
      if (!e.cs_n) check("A0", A0, e.a0);
      check("RD_n", RD_n, e.rd_n);
      check("WR_n", WR_n, e.wr_n);
      check("INTA_n", INTA_n, e.inta_n);
      check("D_oe", D_oe, e.oe);
      if (e.oe) check("D_out", D_out, e.dout);
      check("rsp_valid", rsp_valid, e.rsp_v);
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("vec_valid", vec_valid, e.vec_v);
      check("vec_data", vec_data, m_vec);
      check("cmd_ready", cmd_ready, busy ? 1'b0 : !(h[S-1] && int_enable));
      cyc++;
      if (!CS_n) begin cs_lo++; if (first_cs < 0) first_cs = cyc; end
      if (!INTA_n) begin inta_lo++; if (first_inta < 0) first_inta = cyc; end
      if (!WR_n) wr_lo++;
      if (!RD_n) rd_lo++;
      if (D_oe) oe_hi++;
      if (rsp_valid) rspv_cnt++;
      if (vec_valid) vecv_cnt++;
      if (!CS_n && !INTA_n) overlap_ci++;
      if (!RD_n && !WR_n) overlap_rw++;
   end

   task automatic clr_mon();
      cs_lo = 0; wr_lo = 0; rd_lo = 0; inta_lo = 0; oe_hi = 0;
      rspv_cnt = 0; vecv_cnt = 0; first_cs = -1; first_inta = -1;
   endtask

   task automatic send_cmd(input logic w, input logic a, input logic [7:0] d);
      int n = 0;
      cmd_write = w; cmd_a0 = a; cmd_wdata = d; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_inta(input logic v);
      int n = 0;
      @(negedge clk);
      while (INTA_n !== v && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) check("inta_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_quiet();
      int n = 0;
      @(negedge clk);
      while ((q.size() != 0 || !cmd_ready) && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) check("quiet_timeout", 32'd1, 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      #12;
      check("reset_CS_n", CS_n, 1'b1);
      check("reset_D_oe", D_oe, 1'b0);
      check("reset_ready", cmd_ready, 1'b1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // write a0=0 data 0x13
      clr_mon();
      send_cmd(1'b1, 1'b0, 8'h13);
      k = 0;
      do begin @(negedge clk); k++; end while (!cmd_ready && k < 50);
      check("wr_ready_latency", k, 7);
      check("wr_cs_low", cs_lo, 4);
      check("wr_wr_low", wr_lo, 2);
      check("wr_oe_high", oe_hi, 4);
      wait_quiet();

      // read a0=1 with D_in 0xA5
      clr_mon();
      D_in = 8'hA5;
      send_cmd(1'b0, 1'b1, 8'hEE);
      wait_quiet();
      check("rd_rd_low", rd_lo, 2);
      check("rd_rsp_count", rspv_cnt, 1);
      check("rd_rdata", rsp_rdata, 8'hA5);
      check("rd_oe_never", oe_hi, 0);

      // second write, a0=1 data 0xFC
      send_cmd(1'b1, 1'b1, 8'hFC);
      wait_quiet();

      // interrupt acknowledge, vector 0x48 presented on the second pulse
      clr_mon();
      D_in = 8'h00; int_enable = 1'b1; INT = 1'b1;
      wait_inta(1'b0); INT = 1'b0;
      wait_inta(1'b1); D_in = 8'h48;
      wait_quiet();
      check("ack_inta_low", inta_lo, 4);
      check("ack_cs_low", cs_lo, 0);
      check("ack_vec_count", vecv_cnt, 1);
      check("ack_vec_data", vec_data, 8'h48);

      // INT and cmd_valid seen together in IDLE: acknowledge first
      clr_mon();
      D_in = 8'h21; INT = 1'b1;
      repeat (S) @(posedge clk);
      #1;
      cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_valid = 1'b1;
      wait_inta(1'b0); INT = 1'b0;
      send_cmd(1'b0, 1'b0, 8'h00);
      wait_quiet();
      check("prio_ack_first", first_inta < first_cs, 1'b1);
      check("prio_rdata", rsp_rdata, 8'h21);

      // INT drops during AGAP: sequence still completes with 0x4F
      clr_mon();
      D_in = 8'h00; INT = 1'b1;
      wait_inta(1'b0);
      wait_inta(1'b1); INT = 1'b0; D_in = 8'h4F;
      wait_quiet();
      check("agap_inta_low", inta_lo, 4);
      check("agap_vec_data", vec_data, 8'h4F);

      // INT ignored while interrupts disabled
      clr_mon();
      int_enable = 1'b0; INT = 1'b1;
      send_cmd(1'b1, 1'b1, 8'h5A);
      wait_quiet();
      check("dis_no_inta", inta_lo, 0);
      INT = 1'b0;
      repeat (S + 1) @(posedge clk);
      #1;

      // reset during WSTROBE
      clr_mon();
      send_cmd(1'b1, 1'b0, 8'h3C);
      begin
         int n = 0;
         @(negedge clk);
         while (WR_n !== 1'b0 && n < 50) begin n++; @(negedge clk); end
         if (n >= 50) check("wr_timeout", 32'd1, 32'd0);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      q.delete(); h = '0; m_rdata = 8'h00; m_vec = 8'h00;
      cur_idle = 1'b1; cur_samp_r = 1'b0; cur_samp_v = 1'b0;
      #1;
      check("rst_WR_n", WR_n, 1'b1);
      check("rst_CS_n", CS_n, 1'b1);
      check("rst_D_oe", D_oe, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("rst_no_rsp", rspv_cnt, 0);
      check("rst_ready", cmd_ready, 1'b1);

      check("never_cs_and_inta", overlap_ci, 0);
      check("never_rd_and_wr", overlap_rw, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
